// File: rtl/audio_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : audio_pkg
// Purpose  : Shared definitions for the SD-card-to-audio-FIFO writer path:
//            streamer state encoding, SD block size, audio FIFO depth and a
//            saturating byte-counter helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package audio_pkg;

  localparam int SD_BLOCK_BYTES   = 512;
  localparam int AUDIO_FIFO_DEPTH = 2048;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_SPACE = 3'd1,
    ISSUE      = 3'd2,
    XFER       = 3'd3,
    NEXT       = 3'd4,
    DONE       = 3'd5
  } stream_state_t;

  // 8-bit increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage : audio_pkg
`default_nettype wire

// File: rtl/edge_detect_rise.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : edge_detect_rise
// Purpose  : Registered rising-edge detector. Produces a one-cycle pulse the
//            cycle after sig_i is first sampled high following a low sample.
// Ports    : clk     - clock, all logic on posedge
//            reset_n - synchronous active-low reset
//            sig_i   - level input to watch
//            rise_o  - registered one-cycle rising-edge pulse
// Revision : 1.0 - initial release
// ============================================================================
module edge_detect_rise (
  input  logic clk,
  input  logic reset_n,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;
  logic rise_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= sig_i;
      rise_q <= sig_i & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule : edge_detect_rise
`default_nettype wire

// File: rtl/sd_audio_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sd_audio_streamer
// Purpose  : Writer half of the audio path. Issues block reads to the SD
//            controller and pushes every returned byte into the audio sample
//            FIFO, gated on FIFO space so a whole block always fits.
// Ports    : clk, reset_n         - clock / synchronous active-low reset
//            start, stop, loop_en - streaming control
//            sd_ready, sd_byte_available, sd_dout, sd_rd, sd_address
//                                 - SD controller read interface
//            fifo_count, fifo_full, fifo_din, fifo_wr_en
//                                 - audio FIFO write interface
//            busy, done, overflow_count - status
// Revision : 1.0 - initial release
// ============================================================================
module sd_audio_streamer
  import audio_pkg::*;
#(
  parameter int unsigned BLOCK_BYTES = SD_BLOCK_BYTES,
  parameter int unsigned FIFO_DEPTH  = AUDIO_FIFO_DEPTH,
  parameter int unsigned START_BLOCK = 0,
  parameter int unsigned NUM_BLOCKS  = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  input  logic        sd_ready,
  input  logic        sd_byte_available,
  input  logic [7:0]  sd_dout,
  output logic        sd_rd,
  output logic [31:0] sd_address,
  input  logic [10:0] fifo_count,
  input  logic        fifo_full,
  output logic [7:0]  fifo_din,
  output logic        fifo_wr_en,
  output logic        busy,
  output logic        done,
  output logic [7:0]  overflow_count
);

  localparam int          BC_W        = $clog2(BLOCK_BYTES + 1);
  localparam logic [31:0] START_ADDR  = 32'(START_BLOCK * BLOCK_BYTES);
  localparam logic [31:0] ADDR_STEP   = 32'(BLOCK_BYTES);
  localparam logic [31:0] SPACE_LIMIT = 32'(FIFO_DEPTH - BLOCK_BYTES);
  localparam logic [31:0] LAST_COUNT  = 32'(NUM_BLOCKS);
  localparam logic [BC_W-1:0] BLK_END = BC_W'(BLOCK_BYTES);

  stream_state_t   state_q;
  logic            sd_rd_q;
  logic [31:0]     addr_q;
  logic [31:0]     blk_q;
  logic [BC_W-1:0] byte_cnt_q;
  logic            stop_pending_q;
  logic            busy_q;
  logic            done_q;
  logic [7:0]      ovf_q;
  logic [7:0]      fifo_din_q;
  logic            fifo_wr_en_q;
  logic [7:0]      sd_dout_q;

  logic [31:0]     blk_d;
  logic [7:0]      ovf_d;
  logic            byte_rise;
  logic            space_ok;

  // The byte pulse lags sd_byte_available by one register, so sd_dout is
  // delayed by the same amount to keep data aligned with its strobe.
  edge_detect_rise u_byte_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .sig_i   (sd_byte_available),
    .rise_o  (byte_rise)
  );

  assign blk_d    = blk_q + 32'd1;
  assign ovf_d    = sat_inc8(ovf_q);
  // A read is only issued when a whole block is guaranteed to fit.
  assign space_ok = ({21'd0, fifo_count} <= SPACE_LIMIT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sd_dout_q <= 8'd0;
    end else begin
      sd_dout_q <= sd_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      sd_rd_q        <= 1'b0;
      addr_q         <= START_ADDR;
      blk_q          <= 32'd0;
      byte_cnt_q     <= '0;
      stop_pending_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      ovf_q          <= 8'd0;
      fifo_din_q     <= 8'd0;
      fifo_wr_en_q   <= 1'b0;
    end else begin
      fifo_wr_en_q <= 1'b0;

      // Stop only takes effect at a block boundary; remember it until then.
      if (stop && (state_q != IDLE) && (state_q != DONE)) begin
        stop_pending_q <= 1'b1;
      end

      case (state_q)
        IDLE, DONE: begin
          if (start && !stop) begin
            state_q        <= WAIT_SPACE;
            addr_q         <= START_ADDR;
            blk_q          <= 32'd0;
            done_q         <= 1'b0;
            ovf_q          <= 8'd0;
            busy_q         <= 1'b1;
            stop_pending_q <= 1'b0;
          end
        end

        WAIT_SPACE: begin
          if (stop_pending_q || stop) begin
            state_q        <= IDLE;
            stop_pending_q <= 1'b0;
            busy_q         <= 1'b0;
          end else if (space_ok && sd_ready) begin
            state_q    <= ISSUE;
            byte_cnt_q <= '0;
          end
        end

        ISSUE: begin
          byte_cnt_q <= '0;
          // Raise the request, then hold it until the controller drops
          // ready to show it has accepted the read.
          if (!sd_rd_q) begin
            sd_rd_q <= 1'b1;
          end else if (!sd_ready) begin
            sd_rd_q <= 1'b0;
            state_q <= XFER;
          end
        end

        XFER: begin
          if (byte_rise && (byte_cnt_q < BLK_END)) begin
            byte_cnt_q <= byte_cnt_q + BC_W'(1);
            fifo_din_q <= sd_dout_q;
            if (fifo_full) begin
              ovf_q <= ovf_d;
            end else begin
              fifo_wr_en_q <= 1'b1;
            end
          end else if ((byte_cnt_q == BLK_END) && sd_ready) begin
            state_q <= NEXT;
          end
        end

        NEXT: begin
          blk_q  <= blk_d;
          addr_q <= addr_q + ADDR_STEP;
          if (blk_d == LAST_COUNT) begin
            if (loop_en) begin
              addr_q  <= START_ADDR;
              blk_q   <= 32'd0;
              state_q <= WAIT_SPACE;
            end else begin
              state_q        <= DONE;
              busy_q         <= 1'b0;
              done_q         <= 1'b1;
              stop_pending_q <= 1'b0;
            end
          end else begin
            state_q <= WAIT_SPACE;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          sd_rd_q <= 1'b0;
        end
      endcase
    end
  end

  assign sd_rd          = sd_rd_q;
  assign sd_address     = addr_q;
  assign fifo_din       = fifo_din_q;
  assign fifo_wr_en     = fifo_wr_en_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign overflow_count = ovf_q;

endmodule : sd_audio_streamer
`default_nettype wire
